// File: rtl/leds_pattern_gen.sv
// LED pattern generator: a prescaler produces one pattern step every DIV enabled
// cycles; the step drives blink, binary count, rotate or bounce on the LED bank.
module leds_pattern_gen #(
  parameter int N_LEDS = 8,
  parameter int DIV    = 6000000
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              EN,
  input  logic [1:0]        MODE,
  output logic [N_LEDS-1:0] LED,
  output logic              TICK
);

  localparam int                 CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [N_LEDS-1:0]  LED_ONE = N_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  mode_e             mode_q, mode_d;
  dir_e              dir_q,  dir_d;
  logic [N_LEDS-1:0] led_q,  led_d;
  logic              tick_q, tick_d;

  mode_e             mode_in;
  logic              step;
  logic              mode_change;
  logic [N_LEDS-1:0] led_next;
  logic [N_LEDS-1:0] led_init;
  dir_e              dir_next;

  assign mode_in     = mode_e'(MODE);
  assign step        = EN && (cnt_q == CNT_MAX);
  assign mode_change = (mode_in != mode_q);

  // Pattern loaded when a new mode is taken.
  always_comb begin
    led_init = '0;
    case (mode_in)
      MODE_ROTATE: led_init = LED_ONE;
      MODE_BOUNCE: led_init = LED_ONE;
      default:     led_init = '0;
    endcase
  end

  // Next pattern for one step in the current mode. Bounce only looks at the
  // end bit on the side it is heading to, so off-pattern values keep moving.
  always_comb begin
    led_next = led_q;
    dir_next = dir_q;
    case (mode_q)
      MODE_BLINK:  led_next = ~led_q;
      MODE_COUNT:  led_next = led_q + LED_ONE;
      MODE_ROTATE: led_next = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (led_q[N_LEDS-1]) begin
            led_next = led_q >> 1;
            dir_next = DIR_DOWN;
          end else begin
            led_next = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_next = led_q << 1;
            dir_next = DIR_UP;
          end else begin
            led_next = led_q >> 1;
          end
        end
      end
      default: led_next = led_q;
    endcase
  end

  // A mode change wins over both the step and EN.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    tick_d = 1'b0;
    if (mode_change) begin
      mode_d = mode_in;
      cnt_d  = '0;
      led_d  = led_init;
      dir_d  = DIR_UP;
    end else if (EN) begin
      if (step) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        led_d  = led_next;
        dir_d  = dir_next;
      end else begin
        cnt_d  = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q  <= '0;
      mode_q <= MODE_BLINK;
      dir_q  <= DIR_UP;
      led_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_leds_pattern_gen.sv
// Directed bench for leds_pattern_gen with N_LEDS=8, DIV=4: vector tables for
// count/rotate/bounce runs plus hand sequences for freeze, mode switch and reset.
module tb_leds_pattern_gen;

  localparam int N_LEDS = 8;
  localparam int DIV    = 4;

  logic       CLK  = 1'b0;
  logic       RSTN = 1'b0;
  logic       EN   = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [7:0] LED;
  logic       TICK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] exp_led;
    logic       exp_tick;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] bounce_seq [14];

  leds_pattern_gen #(.N_LEDS(N_LEDS), .DIV(DIV)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .EN   (EN),
    .MODE (MODE),
    .LED  (LED),
    .TICK (TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] led, input logic tick);
    check({name, " led"}, LED, led);
    check({name, " tick"}, {7'd0, TICK}, {7'd0, tick});
  endtask

  // Drive inputs, take one rising edge, sample 1 ns later.
  task automatic cycle(input logic en, input logic [1:0] mode);
    EN   = en;
    MODE = mode;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input string name);
    RSTN = 1'b0;
    EN   = 1'b0;
    MODE = 2'd0;
    #1;
    expect_out({name, " async"}, 8'h00, 1'b0);
    @(posedge CLK);
    #1;
    expect_out({name, " held"}, 8'h00, 1'b0);
    RSTN = 1'b1;
  endtask

  task automatic add_vec(input logic en, input logic [1:0] mode, input logic [7:0] led,
                         input logic tick);
    vec_t v;
    v.en       = en;
    v.mode     = mode;
    v.exp_led  = led;
    v.exp_tick = tick;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].mode);
      expect_out($sformatf("%s[%0d]", name, i), vecs[i].exp_led, vecs[i].exp_tick);
    end
    vecs.delete();
  endtask

  initial begin
    logic [7:0] one;
    int         s;
    logic       t;
    one        = 8'h01;
    bounce_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                   8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    // Edge 1 takes the mode; after that a step lands on edges 5, 9, 13, ...
    do_reset("rst1");
    for (int i = 1; i <= 1 + 256 * DIV; i++) begin
      s = (i - 1) / DIV;
      t = (i > 1) && ((i - 1) % DIV == 0);
      add_vec(1'b1, 2'd1, 8'(s), t);
    end
    run_vecs("count");

    do_reset("rst2");
    for (int i = 1; i <= 1 + 10 * DIV; i++) begin
      s = (i - 1) / DIV;
      t = (i > 1) && ((i - 1) % DIV == 0);
      add_vec(1'b1, 2'd2, one << (s % 8), t);
    end
    run_vecs("rotate");

    do_reset("rst3");
    for (int i = 1; i <= 1 + 30 * DIV; i++) begin
      s = (i - 1) / DIV;
      t = (i > 1) && ((i - 1) % DIV == 0);
      add_vec(1'b1, 2'd3, bounce_seq[s % 14], t);
    end
    run_vecs("bounce");

    // Freeze at LED=05 with cnt=2.
    do_reset("rst4");
    for (int i = 1; i <= 23; i++) cycle(1'b1, 2'd1);
    expect_out("pre_freeze", 8'h05, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2'd1);
      expect_out($sformatf("freeze[%0d]", i), 8'h05, 1'b0);
    end
    cycle(1'b1, 2'd1);
    expect_out("unfreeze1", 8'h05, 1'b0);
    cycle(1'b1, 2'd1);
    expect_out("unfreeze2", 8'h06, 1'b1);

    // Count on to 37, then switch to rotate and blink.
    for (int i = 0; i < (8'h37 - 8'h06) * DIV; i++) cycle(1'b1, 2'd1);
    expect_out("count_37", 8'h37, 1'b1);
    cycle(1'b1, 2'd2);
    expect_out("to_rotate", 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd2);
      expect_out($sformatf("rot_wait[%0d]", i), 8'h01, 1'b0);
    end
    cycle(1'b1, 2'd2);
    expect_out("rot_step", 8'h02, 1'b1);
    cycle(1'b1, 2'd0);
    expect_out("to_blink", 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0);
    expect_out("blink_wait", 8'h00, 1'b0);
    cycle(1'b1, 2'd0);
    expect_out("blink_on", 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0);
    expect_out("blink_off", 8'h00, 1'b1);

    // Mode change still applies while disabled; prescaler restarts from 0.
    cycle(1'b0, 2'd3);
    expect_out("dis_to_bounce", 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd3);
      expect_out($sformatf("dis_hold[%0d]", i), 8'h01, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd3);
      expect_out($sformatf("bnc_wait[%0d]", i), 8'h01, 1'b0);
    end
    cycle(1'b1, 2'd3);
    expect_out("bnc_step", 8'h02, 1'b1);

    // Asynchronous reset mid-period at LED=A5.
    do_reset("rst6");
    for (int i = 0; i < 1 + 8'hA5 * DIV; i++) cycle(1'b1, 2'd1);
    expect_out("count_a5", 8'hA5, 1'b1);
    cycle(1'b1, 2'd1);
    cycle(1'b1, 2'd1);
    expect_out("mid_period", 8'hA5, 1'b0);
    #2;
    RSTN = 1'b0;
    #1;
    expect_out("async_clear", 8'h00, 1'b0);
    @(posedge CLK);
    #1;
    expect_out("rst_hold", 8'h00, 1'b0);
    RSTN = 1'b1;
    cycle(1'b1, 2'd1);
    expect_out("restart", 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1);
    expect_out("restart_wait", 8'h00, 1'b0);
    cycle(1'b1, 2'd1);
    expect_out("restart_step", 8'h01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
